pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order pipeline.
// Produces the PC and pipeline-register load enables, the bubble-insert flushes
// and the data-memory request. Stalls are raised for slow data memory, for
// taken branches (flush) and for load-use dependencies, and a fault is latched
// if memory never answers. stall_cnt counts cycles with the PC frozen.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        mem_access,
    input  logic        dm_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        dm_req,
    output logic        bus_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;

    // Ungated control values; the external outputs force these low during reset.
    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic if_id_flush_c, id_ex_flush_c, dm_req_c, bus_err_c;

    logic load_use;
    logic mem_stall;

    // A load writing r0 never creates a real dependency, so ex_rt==0 is excluded.
    assign load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign mem_stall = mem_access && !dm_ready;

    // State and wait counter register; reset abandons any outstanding access.
    // NOTE: sequential state uses non-blocking (<=) so all registers update
    // together from pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state and control decode: memory stall > branch flush > load-use > normal.
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        id_ex_en_c    = 1'b0;
        ex_mem_en_c   = 1'b0;
        mem_wb_en_c   = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        dm_req_c      = 1'b0;
        bus_err_c     = 1'b0;

        unique case (state)
            RUN: begin
                dm_req_c = mem_access;
                if (mem_stall) begin
                    // Whole pipe freezes while memory is busy.
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else if (branch_taken) begin
                    pc_en_c       = 1'b1;
                    if_id_en_c    = 1'b1;
                    id_ex_en_c    = 1'b1;
                    ex_mem_en_c   = 1'b1;
                    mem_wb_en_c   = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, drop a bubble into EX, let the load advance.
                    id_ex_en_c    = 1'b1;
                    ex_mem_en_c   = 1'b1;
                    mem_wb_en_c   = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else begin
                    pc_en_c     = 1'b1;
                    if_id_en_c  = 1'b1;
                    id_ex_en_c  = 1'b1;
                    ex_mem_en_c = 1'b1;
                    mem_wb_en_c = 1'b1;
                end
            end

            MEM_WAIT: begin
                dm_req_c = mem_access;
                if (!dm_ready) begin
                    if (wait_cnt == TIMEOUT_CNT) begin
                        state_nxt = FAULT;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end else begin
                    // EX was frozen, so branch and load-use are re-judged in RUN.
                    pc_en_c      = 1'b1;
                    if_id_en_c   = 1'b1;
                    id_ex_en_c   = 1'b1;
                    ex_mem_en_c  = 1'b1;
                    mem_wb_en_c  = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end
            end

            FAULT: begin
                // Terminal until reset; the pipe stays frozen and memory is released.
                bus_err_c = 1'b1;
            end

            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Saturating count of frozen-PC cycles; a faulted pipe is not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if (!pc_en_c && (state != FAULT) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Reset is applied combinationally so every control output drops immediately.
    assign pc_en       = rst & pc_en_c;
    assign if_id_en    = rst & if_id_en_c;
    assign id_ex_en    = rst & id_ex_en_c;
    assign ex_mem_en   = rst & ex_mem_en_c;
    assign mem_wb_en   = rst & mem_wb_en_c;
    assign if_id_flush = rst & if_id_flush_c;
    assign id_ex_flush = rst & id_ex_flush_c;
    assign dm_req      = rst & dm_req_c;
    assign bus_err     = rst & bus_err_c;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle RUN
// vectors followed by hand-written multi-cycle sequences (memory wait,
// timeout fault, asynchronous reset, counter saturation).
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_mem_read, branch_taken, mem_access, dm_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, dm_req, bus_err;
    logic [15:0] stall_cnt;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, dm_req, bus_err}
    logic [8:0]  out_vec;
    assign out_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                      if_id_flush, id_ex_flush, dm_req, bus_err};

    localparam logic [8:0] O_NORMAL = 9'b11111_00_0_0;
    localparam logic [8:0] O_LDUSE  = 9'b00111_01_0_0;
    localparam logic [8:0] O_BRANCH = 9'b11111_11_0_0;
    localparam logic [8:0] O_FREEZE = 9'b00000_00_0_0;
    localparam logic [8:0] O_FAULT  = 9'b00000_00_0_1;
    localparam logic [8:0] O_DMREQ  = 9'b00000_00_1_0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .mem_access   (mem_access),
        .dm_ready     (dm_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .dm_req       (dm_req),
        .bus_err      (bus_err),
        .stall_cnt    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       ex_mem_read;
        logic [4:0] ex_rt;
        logic       branch_taken;
        logic       mem_access;
        logic       dm_ready;
        logic [8:0] exp_out;
        int         exp_inc;
    } vec_t;

    vec_t vecs[11];
    int   passed = 0;
    int   total  = 0;
    int   exp_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                          input logic [4:0] xrt, input logic br, input logic ma,
                          input logic rdy);
        id_rs        = rs;
        id_rt        = rt;
        ex_mem_read  = mr;
        ex_rt        = xrt;
        branch_taken = br;
        mem_access   = ma;
        dm_ready     = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name, rs, rt, mr, ex_rt, br, ma, rdy, expected outputs, stall increment
        vecs[0]  = '{"idle",            5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORMAL, 0};
        vecs[1]  = '{"lduse_rs",        5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LDUSE,  1};
        vecs[2]  = '{"lduse_r0",        5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_NORMAL, 0};
        vecs[3]  = '{"lduse_rt",        5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LDUSE,  1};
        vecs[4]  = '{"no_load",         5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_NORMAL, 0};
        vecs[5]  = '{"no_match",        5'd5, 5'd4, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, O_NORMAL, 0};
        vecs[6]  = '{"branch_lduse",    5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_BRANCH, 0};
        vecs[7]  = '{"branch",          5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, O_BRANCH, 0};
        vecs[8]  = '{"mem_ready",       5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_NORMAL | O_DMREQ, 0};
        vecs[9]  = '{"mem_ready_lduse", 5'd9, 5'd1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, O_LDUSE | O_DMREQ, 1};
        vecs[10] = '{"mem_ready_br",    5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, O_BRANCH | O_DMREQ, 0};

        rst = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #8;
        check("reset_outputs", 32'(out_vec), 32'(O_FREEZE));
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        #4 rst = 1'b1;

        // Single-cycle RUN vectors.
        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].id_rs, vecs[i].id_rt, vecs[i].ex_mem_read, vecs[i].ex_rt,
                   vecs[i].branch_taken, vecs[i].mem_access, vecs[i].dm_ready);
            #1;
            check({vecs[i].name, "_out"}, 32'(out_vec), 32'(vecs[i].exp_out));
            tick();
            exp_stall += vecs[i].exp_inc;
            check({vecs[i].name, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        end

        // Memory wait: three not-ready cycles, then ready with a pending branch
        // and load-use that must be ignored while waiting.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("memwait_frozen", 32'(out_vec), 32'(O_DMREQ));
            tick();
            exp_stall++;
        end
        set_in(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
        #1;
        check("memwait_release", 32'(out_vec), 32'(O_NORMAL | O_DMREQ));
        tick();
        check("memwait_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        check("memwait_back_in_run", 32'(out_vec), 32'(O_BRANCH | O_DMREQ));
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Timeout: cycles 1..16 frozen with dm_req, cycle 17 faulted.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            #1;
            check($sformatf("timeout_cyc%0d", c), 32'(out_vec), 32'(O_DMREQ));
            tick();
            exp_stall++;
        end
        #1;
        check("timeout_fault", 32'(out_vec), 32'(O_FAULT));
        check("timeout_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        dm_ready = 1'b1;
        tick();
        tick();
        check("fault_sticky", 32'(out_vec), 32'(O_FAULT));
        check("fault_no_count", 32'(stall_cnt), 32'(exp_stall));

        // Reset out of FAULT.
        #2 rst = 1'b0;
        #1;
        check("fault_reset_out", 32'(out_vec), 32'(O_FREEZE));
        check("fault_reset_cnt", 32'(stall_cnt), 32'd0);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        exp_stall = 0;
        #1;
        check("fault_reset_run", 32'(out_vec), 32'(O_NORMAL));
        tick();

        // Async reset in the middle of MEM_WAIT, between clock edges.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check("pre_reset_stall_cnt", 32'(stall_cnt), 32'd2);
        #3 rst = 1'b0;
        #1;
        check("async_reset_out", 32'(out_vec), 32'(O_FREEZE));
        check("async_reset_cnt", 32'(stall_cnt), 32'd0);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("post_reset_run", 32'(out_vec), 32'(O_BRANCH));
        tick();
        check("post_reset_cnt", 32'(stall_cnt), 32'd0);

        // Saturation: hold a load-use stall for 65540 edges.
        set_in(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
        tick();
        check("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
        check("sat_outputs", 32'(out_vec), 32'(O_LDUSE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
